voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Converts decoded MIDI note events into per-voice gate state and the note-event port set of synth_engine
//  (keys_on, note_on, cur_key_adr, cur_key_val, cur_vel_on, cur_vel_off). Sits between midi_decoder and synth_engine.
//  Consumes voice_free from the envelope generators. Steals the oldest voice when all voices are busy.
// PARAMETERS
//  VOICES      8   number of synth voices
//  V_WIDTH     3   log2(VOICES)
//  HOLD_CYCLES 64  sys_clk cycles note_on stays high; must exceed one n_xxxx_zero period of synth_engine
//  AGE_W       8   width of per-voice age counter (saturating)
// PORTS
//  sys_clk      in   1        system clock, all logic on rising edge
//  iRST_N       in   1        asynchronous active-low reset
//  ev_valid     in   1        note event present
//  ev_ready     out  1        allocator accepts event (transfer on ev_valid & ev_ready)
//  ev_on        in   1        1 = note-on, 0 = note-off
//  ev_key       in   7        MIDI key number
//  ev_vel       in   7        MIDI velocity
//  all_off      in   1        single-cycle pulse: release all voices
//  voice_free   in   VOICES   from env gen: voice envelope finished
//  keys_on      out  VOICES   gate per voice
//  note_on      out  1        trigger strobe, held HOLD_CYCLES
//  cur_key_adr  out  V_WIDTH  voice index of last assignment/release
//  cur_key_val  out  8        {1'b0,key} of last assignment
//  cur_vel_on   out  8        {1'b0,vel} of last note-on
//  cur_vel_off  out  8        {1'b0,vel} of last note-off
// BEHAVIOUR
//  Reset: all outputs 0 except ev_ready=1; voice key table 0; ages 0; FSM=IDLE. Reset mid-scan/hold aborts; event lost.
//  FSM: IDLE -(transfer)-> SCAN -(VOICES cycles)-> COMMIT -(assign)-> HOLD -(HOLD_CYCLES)-> IDLE;
//       COMMIT -(release or no match)-> IDLE. ev_ready=1 only in IDLE.
//  Note-on with ev_vel=0 is treated as note-off.
//  SCAN visits voice 0..VOICES-1, one per cycle, recording the best candidate in this priority order:
//   1 keys_on=1 & key match (retrigger)
//   2 keys_on=0 & voice_free=1
//   3 keys_on=0 (still releasing)
//   4 max age (steal)
//  Ties in any class go to the lowest index.
//  Note-on COMMIT (edge ending cycle VOICES+1 after transfer):
//   keys_on[v]<=1; table[v]<=key; cur_* updated; note_on<=1; age[v]<=0; other assigned ages +1, saturating at 2^AGE_W-1.
//  Note-off COMMIT: first voice with keys_on=1 & key match -> keys_on[v]<=0, cur_key_adr<=v, cur_vel_off<=vel.
//   No match: event dropped silently. note_on is not touched.
//  cur_* stable between commits.
//  Retrigger/steal keep keys_on[v]=1; note_on alone retriggers the envelope.
//  all_off: clears keys_on in any state, aborts SCAN to IDLE. Beats a COMMIT in the same cycle (keys_on=0, note_on=0).
//  HOLD is not aborted by all_off except for note_on<=0.
//  Duplicate note-on of a held key reuses its voice. A single voice is never assigned twice.
// CONFIGURATION
//  SUSTAIN_PEDAL_EN defined:
//   extra input sustain (1 bit, CC64>=64).
//   While sustain=1, a matching note-off sets sustained[v] instead of clearing keys_on.
//   On sustain 1->0, all keys_on[v] with sustained[v] clear in one cycle.
//   A note-on retrigger clears sustained[v]. all_off clears sustained.
//  Not defined: no sustain port; note-off clears keys_on immediately.
// STRUCTURE
//  synth_voice_pkg: FSM state encoding (IDLE, SCAN, COMMIT, HOLD), candidate-class codes, AGE_W/HOLD_CYCLES defaults.
//  Sub-module voice_age_tracker: per-voice saturating age counters. Interface: reset-on-assign index plus oldest-index output.
// TESTING
//  1 Reset, note-on key 60 vel 100 -> at cycle 9: keys_on=8'h01, cur_key_adr=0, cur_key_val=60, cur_vel_on=100, note_on high 64 cycles
//  2 Note-on keys 60..67 then key 72 with all voice_free=0 -> voice 0 (oldest) stolen, keys_on stays 8'hFF, cur_key_val=72
//  3 Note-on 60 then note-off 60 vel 40 -> keys_on[0]=0, cur_vel_off=40, note_on not pulsed; note-off 61 -> no change
//  4 Note-on 64 vel 0 while voice 2 holds 64 -> keys_on[2] cleared
//  5 all_off coincident with COMMIT of note-on -> keys_on=0, note_on=0, FSM IDLE next cycle
//  6 (SUSTAIN_PEDAL_EN) sustain=1, note-off 60 -> keys_on[0] stays 1; sustain 1->0 -> keys_on[0]=0 next cycle

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// voice_allocator_pkg: shared state/candidate encodings and defaults for the voice allocator.
package voice_allocator_pkg;
  localparam int HOLD_CYCLES_DEF = 64;
  localparam int AGE_W_DEF = 8;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_HOLD} state_e;
  typedef enum logic [1:0] {C_MATCH, C_FREE, C_REL, C_STEAL} cls_e;
  function automatic cls_e classify(logic gate, logic free, logic hit);
    if (gate) return hit ? C_MATCH : C_STEAL;
    if (free) return C_FREE;
    return C_REL;
  endfunction
endpackage

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: valid/ready note-event channel from midi_decoder into the allocator.
interface voice_allocator_if;
  logic ev_valid;
  logic ev_ready;
  logic ev_on;
  logic [6:0] ev_key;
  logic [6:0] ev_vel;
  modport master (output ev_valid, ev_on, ev_key, ev_vel, input ev_ready);
  modport slave (input ev_valid, ev_on, ev_key, ev_vel, output ev_ready);
endinterface

// File: rtl/voice_allocator_age_tracker.sv
// voice_allocator_age_tracker: per-voice saturating age counters with oldest-voice lookup.
module voice_allocator_age_tracker #(
  parameter int VOICES = 8,
  parameter int V_WIDTH = 3,
  parameter int AGE_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               assign_en,
  input  logic [V_WIDTH-1:0] assign_idx,
  input  logic [VOICES-1:0]  active,
  output logic [V_WIDTH-1:0] oldest_idx
);
  logic [AGE_W-1:0] age_q [VOICES];
  logic [AGE_W-1:0] age_d [VOICES];
  always_comb begin
    for (int i = 0; i < VOICES; i++)
      age_d[i] = !assign_en ? age_q[i] :
                 (V_WIDTH'(i) == assign_idx) ? '0 :
                 (active[i] && age_q[i] != '1) ? age_q[i] + 1'b1 : age_q[i];
  end
  // strict compare keeps the lowest index on ties
  always_comb begin
    oldest_idx = '0;
    for (int i = 0; i < VOICES; i++)
      if (age_q[i] > age_q[oldest_idx]) oldest_idx = V_WIDTH'(i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) age_q <= '{default: '0};
    else age_q <= age_d;
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: maps note events to voice gates and synth_engine note ports, stealing the oldest voice when full.
// Optional SUSTAIN_PEDAL_EN adds a sustain input that defers note-off releases until the pedal lifts.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int VOICES = 8,
  parameter int V_WIDTH = 3,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int AGE_W = AGE_W_DEF
) (
  input  logic               sys_clk,
  input  logic               iRST_N,
  voice_allocator_if.slave   ev,
  input  logic               all_off,
  input  logic [VOICES-1:0]  voice_free,
`ifdef SUSTAIN_PEDAL_EN
  input  logic               sustain,
`endif
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off
);
  localparam int HC_W = $clog2(HOLD_CYCLES + 1);
  state_e state_q, state_d;
  cls_e best_cls_q, best_cls_d, cls;
  logic [V_WIDTH-1:0] idx_q, idx_d, best_idx_q, best_idx_d, oldest, v;
  logic [HC_W-1:0] hold_q, hold_d;
  logic [6:0] key_q, key_d, vel_q, vel_d;
  logic is_on_q, is_on_d;
  logic [6:0] key_tab_q [VOICES];
  logic [6:0] key_tab_d [VOICES];
  logic [VOICES-1:0] keys_on_q, keys_on_d;
  logic note_on_q, note_on_d, assign_en;
  logic [V_WIDTH-1:0] adr_q, adr_d;
  logic [7:0] kval_q, kval_d, von_q, von_d, voff_q, voff_d;
`ifdef SUSTAIN_PEDAL_EN
  logic [VOICES-1:0] sus_q, sus_d;
  logic sustain_q;
`endif
  voice_allocator_age_tracker #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .AGE_W(AGE_W)) u_age (
    .clk(sys_clk), .rst_n(iRST_N), .assign_en(assign_en), .assign_idx(v),
    .active(keys_on_q), .oldest_idx(oldest)
  );
  assign cls = classify(keys_on_q[idx_q], voice_free[idx_q], key_tab_q[idx_q] == key_q);
  // no better class seen during the scan means every voice is gated: steal
  assign v = (best_cls_q == C_STEAL) ? oldest : best_idx_q;
  assign ev.ev_ready = state_q == S_IDLE;
  assign keys_on = keys_on_q;
  assign note_on = note_on_q;
  assign cur_key_adr = adr_q;
  assign cur_key_val = kval_q;
  assign cur_vel_on = von_q;
  assign cur_vel_off = voff_q;
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    best_cls_d = best_cls_q;
    best_idx_d = best_idx_q;
    hold_d = hold_q;
    key_d = key_q;
    vel_d = vel_q;
    is_on_d = is_on_q;
    key_tab_d = key_tab_q;
    keys_on_d = keys_on_q;
    note_on_d = note_on_q;
    adr_d = adr_q;
    kval_d = kval_q;
    von_d = von_q;
    voff_d = voff_q;
    assign_en = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
    sus_d = sus_q;
`endif
    case (state_q)
      S_IDLE:
        if (ev.ev_valid) begin
          state_d = S_SCAN;
          idx_d = '0;
          best_cls_d = C_STEAL;
          best_idx_d = '0;
          key_d = ev.ev_key;
          vel_d = ev.ev_vel;
          is_on_d = ev.ev_on && ev.ev_vel != '0;
        end
      S_SCAN: begin
        if (cls < best_cls_q) begin
          best_cls_d = cls;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 1'b1;
        if (idx_q == V_WIDTH'(VOICES - 1)) state_d = S_COMMIT;
      end
      S_COMMIT:
        if (all_off) state_d = S_IDLE;
        else if (is_on_q) begin
          keys_on_d[v] = 1'b1;
          key_tab_d[v] = key_q;
          adr_d = v;
          kval_d = {1'b0, key_q};
          von_d = {1'b0, vel_q};
          note_on_d = 1'b1;
          hold_d = '0;
          assign_en = 1'b1;
          state_d = S_HOLD;
`ifdef SUSTAIN_PEDAL_EN
          sus_d[v] = 1'b0;
`endif
        end else begin
          state_d = S_IDLE;
          if (best_cls_q == C_MATCH) begin
            adr_d = best_idx_q;
            voff_d = {1'b0, vel_q};
`ifdef SUSTAIN_PEDAL_EN
            if (sustain) sus_d[best_idx_q] = 1'b1;
            else keys_on_d[best_idx_q] = 1'b0;
`else
            keys_on_d[best_idx_q] = 1'b0;
`endif
          end
        end
      S_HOLD:
        if (hold_q == HC_W'(HOLD_CYCLES - 1)) begin
          state_d = S_IDLE;
          note_on_d = 1'b0;
        end else hold_d = hold_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
`ifdef SUSTAIN_PEDAL_EN
    if (sustain_q && !sustain) begin
      keys_on_d = keys_on_d & ~sus_d;
      sus_d = '0;
    end
`endif
    if (all_off) begin
      keys_on_d = '0;
      note_on_d = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
      sus_d = '0;
`endif
      if (state_q == S_SCAN) state_d = S_IDLE;
    end
  end
  always_ff @(posedge sys_clk or negedge iRST_N)
    if (!iRST_N) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      best_cls_q <= C_STEAL;
      best_idx_q <= '0;
      hold_q <= '0;
      key_q <= '0;
      vel_q <= '0;
      is_on_q <= 1'b0;
      key_tab_q <= '{default: '0};
      keys_on_q <= '0;
      note_on_q <= 1'b0;
      adr_q <= '0;
      kval_q <= '0;
      von_q <= '0;
      voff_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      best_cls_q <= best_cls_d;
      best_idx_q <= best_idx_d;
      hold_q <= hold_d;
      key_q <= key_d;
      vel_q <= vel_d;
      is_on_q <= is_on_d;
      key_tab_q <= key_tab_d;
      keys_on_q <= keys_on_d;
      note_on_q <= note_on_d;
      adr_q <= adr_d;
      kval_q <= kval_d;
      von_q <= von_d;
      voff_q <= voff_d;
    end
`ifdef SUSTAIN_PEDAL_EN
  always_ff @(posedge sys_clk or negedge iRST_N)
    if (!iRST_N) begin
      sus_q <= '0;
      sustain_q <= 1'b0;
    end else begin
      sus_q <= sus_d;
      sustain_q <= sustain;
    end
`endif
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed and random note events checked against a behavioural voice-assignment model.
module tb_voice_allocator;
  logic sys_clk = 1'b0, iRST_N = 1'b0, all_off = 1'b0, m_sustain = 1'b0;
  logic [7:0] voice_free = '0, keys_on, cur_key_val, cur_vel_on, cur_vel_off;
  logic note_on;
  logic [2:0] cur_key_adr;
  int compared = 0, mismatched = 0;
  logic [7:0] m_gate = '0, m_sus = '0;
  int m_key [8];
  int m_stamp [8];
  int n_assign = 0, m_adr = 0, m_kval = 0, m_von = 0, m_voff = 0;
  bit m_note = 1'b0;
  voice_allocator_if ev_if ();
  voice_allocator dut (
    .sys_clk(sys_clk), .iRST_N(iRST_N), .ev(ev_if), .all_off(all_off), .voice_free(voice_free),
`ifdef SUSTAIN_PEDAL_EN
    .sustain(m_sustain),
`endif
    .keys_on(keys_on), .note_on(note_on), .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
    .cur_vel_on(cur_vel_on), .cur_vel_off(cur_vel_off)
  );
  always #5 sys_clk = ~sys_clk;
  // age = assignments made since this voice was assigned, saturating
  function automatic int age(int v);
    int a = n_assign - m_stamp[v];
    return a > 255 ? 255 : a;
  endfunction
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic check_all(string tag);
    check({tag, ".keys_on"}, 32'(keys_on), 32'(m_gate));
    check({tag, ".note_on"}, 32'(note_on), 32'(m_note));
    check({tag, ".ev_ready"}, 32'(ev_if.ev_ready), 32'(!m_note));
    check({tag, ".key_adr"}, 32'(cur_key_adr), m_adr);
    check({tag, ".key_val"}, 32'(cur_key_val), m_kval);
    check({tag, ".vel_on"}, 32'(cur_vel_on), m_von);
    check({tag, ".vel_off"}, 32'(cur_vel_off), m_voff);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!ev_if.ev_ready && n < 300) begin
      @(negedge sys_clk);
      n++;
    end
    check("ready_timeout", 32'(ev_if.ev_ready), 32'd1);
    m_note = 1'b0;
  endtask
  task automatic model_event(bit on, int k, int vel, logic [7:0] fr);
    int hit = -1, fre = -1, rel = -1, old = 0, v;
    for (int i = 0; i < 8; i++) begin
      if (m_gate[i] && m_key[i] == k && hit < 0) hit = i;
      if (!m_gate[i] && fr[i] && fre < 0) fre = i;
      if (!m_gate[i] && rel < 0) rel = i;
      if (age(i) > age(old)) old = i;
    end
    if (on && vel != 0) begin
      v = hit >= 0 ? hit : fre >= 0 ? fre : rel >= 0 ? rel : old;
      m_gate[v] = 1'b1;
      m_sus[v] = 1'b0;
      m_key[v] = k;
      n_assign++;
      m_stamp[v] = n_assign;
      m_adr = v;
      m_kval = k;
      m_von = vel;
      m_note = 1'b1;
    end else if (hit >= 0) begin
      if (m_sustain) m_sus[hit] = 1'b1;
      else m_gate[hit] = 1'b0;
      m_adr = hit;
      m_voff = vel;
    end
  endtask
  task automatic start_event(bit on, int k, int vel, logic [7:0] fr);
    wait_idle();
    voice_free = fr;
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on = on;
    ev_if.ev_key = 7'(k);
    ev_if.ev_vel = 7'(vel);
    @(posedge sys_clk);
    @(negedge sys_clk);
    ev_if.ev_valid = 1'b0;
  endtask
  task automatic send(string tag, bit on, int k, int vel, logic [7:0] fr);
    start_event(on, k, vel, fr);
    repeat (8) @(negedge sys_clk);
    check({tag, ".precommit"}, 32'(keys_on), 32'(m_gate));
    @(negedge sys_clk);
    model_event(on, k, vel, fr);
    check_all(tag);
  endtask
  task automatic pulse_all_off();
    wait_idle();
    all_off = 1'b1;
    @(negedge sys_clk);
    all_off = 1'b0;
    m_gate = '0;
    m_sus = '0;
    check("all_off.keys_on", 32'(keys_on), 32'd0);
  endtask
  initial begin
    ev_if.ev_valid = 1'b0;
    ev_if.ev_on = 1'b0;
    ev_if.ev_key = '0;
    ev_if.ev_vel = '0;
    repeat (3) @(negedge sys_clk);
    iRST_N = 1'b1;
    @(negedge sys_clk);
    check_all("reset");
    send("t1", 1'b1, 60, 100, 8'h00);
    repeat (63) @(negedge sys_clk);
    check("t1.hold_last", 32'(note_on), 32'd1);
    check("t1.busy", 32'(ev_if.ev_ready), 32'd0);
    @(negedge sys_clk);
    check("t1.hold_end", 32'(note_on), 32'd0);
    check("t1.idle", 32'(ev_if.ev_ready), 32'd1);
    send("t3.off", 1'b0, 60, 40, 8'h00);
    send("t3.miss", 1'b0, 61, 33, 8'h00);
    for (int k = 60; k < 68; k++) send("t2.fill", 1'b1, k, k - 10, 8'h00);
    send("t2.steal", 1'b1, 72, 90, 8'h00);
    check("t2.full", 32'(keys_on), 32'hFF);
    check("t2.victim", 32'(cur_key_adr), 32'd0);
    pulse_all_off();
    send("t4.a", 1'b1, 60, 70, 8'h00);
    send("t4.b", 1'b1, 62, 71, 8'h00);
    send("t4.c", 1'b1, 64, 72, 8'h00);
    send("t4.vel0", 1'b1, 64, 0, 8'h00);
    check("t4.v2_off", 32'(keys_on), 32'h03);
    start_event(1'b1, 70, 90, 8'h00);
    repeat (8) @(negedge sys_clk);
    all_off = 1'b1;
    @(negedge sys_clk);
    all_off = 1'b0;
    m_gate = '0;
    check_all("t5");
    start_event(1'b1, 71, 91, 8'h00);
    repeat (3) @(negedge sys_clk);
    all_off = 1'b1;
    @(negedge sys_clk);
    all_off = 1'b0;
    check_all("scan_abort");
    send("after_abort", 1'b1, 71, 91, 8'h0F);
`ifdef SUSTAIN_PEDAL_EN
    pulse_all_off();
    send("t6.on", 1'b1, 60, 80, 8'h00);
    m_sustain = 1'b1;
    send("t6.off", 1'b0, 60, 30, 8'h00);
    check("t6.held", 32'(keys_on[0]), 32'd1);
    m_sustain = 1'b0;
    @(negedge sys_clk);
    m_gate = m_gate & ~m_sus;
    m_sus = '0;
    check("t6.release", 32'(keys_on), 32'(m_gate));
`endif
    for (int n = 0; n < 48; n++) begin
      if ($urandom_range(0, 11) == 0) pulse_all_off();
      send("rand", $urandom_range(0, 9) < 6, 60 + $urandom_range(0, 9),
           $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 127), 8'($urandom));
    end
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
